// File: rtl/nibble_serial_adder_ctrl.sv
// Serial WIDTH-bit adder/subtractor: one shared 4-bit ripple-carry slice processes a
// nibble per clock, LSB first, behind valid/ready handshakes on both sides.
module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int SLICE_W = 4;
  localparam int NSLICE  = WIDTH / SLICE_W;
  localparam int IDX_W   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSLICE - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1'b1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   a_r;
  logic [WIDTH-1:0]   b_r;
  logic [WIDTH-1:0]   acc_r;
  logic [IDX_W-1:0]   idx_r;
  logic               carry_r;
  logic               out_valid_r;
  logic [WIDTH-1:0]   sum_r;
  logic               cout_r;
  logic               ovf_r;
  logic               busy_r;

  logic [IDX_W+1:0]   slice_lo_s;
  logic [4:0]         add_s;
  logic [WIDTH-1:0]   acc_next_s;

  function automatic logic [4:0] ripple_add4(input logic [3:0] x, input logic [3:0] y,
                                             input logic ci);
    logic       c;
    logic [3:0] s;
    c = ci;
    for (int k = 0; k < 4; k++) begin
      s[k] = x[k] ^ y[k] ^ c;
      c    = (x[k] & y[k]) | (x[k] & c) | (y[k] & c);
    end
    return {c, s};
  endfunction

  assign slice_lo_s = {idx_r, 2'b00};

  // Current nibble sum and the accumulator with that nibble merged in.
  always_comb begin
    add_s      = ripple_add4(a_r[slice_lo_s +: SLICE_W], b_r[slice_lo_s +: SLICE_W], carry_r);
    acc_next_s = acc_r;
    acc_next_s[slice_lo_s +: SLICE_W] = add_s[3:0];
  end

  // Sequencer: accept operands, walk the slices, hold the result until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      acc_r       <= {WIDTH{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      carry_r     <= 1'b0;
      out_valid_r <= 1'b0;
      sum_r       <= {WIDTH{1'b0}};
      cout_r      <= 1'b0;
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub;
            idx_r   <= {IDX_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= RUN;
          end
        end
        RUN: begin
          acc_r   <= acc_next_s;
          carry_r <= add_s[4];
          idx_r   <= idx_r + IDX_ONE;
          if (idx_r == IDX_LAST) begin
            sum_r       <= acc_next_s;
            cout_r      <= add_s[4];
            // b_r is already inverted for subtraction, so one rule covers both modes.
            ovf_r       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                           (acc_next_s[WIDTH-1] != a_r[WIDTH-1]);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = ~rst & (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign ovf       = ovf_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed bench for nibble_serial_adder_ctrl: expected results are queued at issue
// time and popped when out_valid appears.
module tb_nibble_serial_adder_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  logic [WIDTH+1:0] sb_q[$];

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: signed range test for overflow, 17-bit add for carry.
  task automatic model(input logic [15:0] x, input logic [15:0] y, input logic s,
                       output logic [17:0] r);
    logic [16:0] full;
    int          sx, sy, sr;
    full = s ? ({1'b0, x} + {1'b0, ~y} + 17'd1) : ({1'b0, x} + {1'b0, y});
    sx = int'($signed(x));
    sy = int'($signed(y));
    sr = s ? (sx - sy) : (sx + sy);
    r  = {full[15:0], full[16], ((sr > 32767) || (sr < -32768)) ? 1'b1 : 1'b0};
  endtask

  task automatic issue(input logic [15:0] a_v, input logic [15:0] b_v, input logic s_v,
                       input logic push, input logic [17:0] exp);
    for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    check("in_ready_before_issue", {31'd0, in_ready}, 32'd1);
    a = a_v; b = b_v; sub = s_v; in_valid = 1'b1;
    if (push) sb_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; sub = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic await_result();
    logic [17:0] exp;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("out_valid_early", {31'd0, out_valid}, 32'd0);
      check("busy_run", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, {31'd0, out_valid});
    end else begin
      exp = sb_q.pop_front();
      check("sum", {16'd0, sum}, {16'd0, exp[17:2]});
      check("cout", {31'd0, cout}, {31'd0, exp[1]});
      check("ovf", {31'd0, ovf}, {31'd0, exp[0]});
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("busy_after_hs", {31'd0, busy}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;
  endtask

  task automatic full_op(input logic [15:0] a_v, input logic [15:0] b_v, input logic s_v,
                         input logic [17:0] exp);
    issue(a_v, b_v, s_v, 1'b1, exp);
    await_result();
    release_result();
  endtask

  initial begin
    logic [17:0] r;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b1; in_valid = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b0; out_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_sum", {16'd0, sum}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

    full_op(16'h1234, 16'h4321, 1'b0, {16'h5555, 1'b0, 1'b0});
    full_op(16'hFFFF, 16'h0001, 1'b0, {16'h0000, 1'b1, 1'b0});
    full_op(16'h7FFF, 16'h0001, 1'b0, {16'h8000, 1'b0, 1'b1});
    full_op(16'h0005, 16'h0007, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    full_op(16'h8000, 16'h0001, 1'b1, {16'h7FFF, 1'b1, 1'b1});

    // Backpressure: result must be held and new operands refused.
    issue(16'h00FF, 16'h0001, 1'b0, 1'b1, {16'h0100, 1'b0, 1'b0});
    await_result();
    a = 16'hAAAA; b = 16'h5555; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_sum", {16'd0, sum}, 32'h0100);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    release_result();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_no_ghost_valid", {31'd0, out_valid}, 32'd0);
      check("bp_no_ghost_sum", {16'd0, sum}, 32'h0100);
    end

    // out_ready already high when the result lands.
    out_ready = 1'b1;
    issue(16'h0F0F, 16'h00F1, 1'b0, 1'b1, {16'h1000, 1'b0, 1'b0});
    await_result();
    release_result();

    for (int n = 0; n < 8; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      model(ra, rb, rs, r);
      full_op(ra, rb, rs, r);
    end

    // Reset sampled on the edge that processes slice 2.
    issue(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 18'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_sum", {16'd0, sum}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("midrst_no_result", {31'd0, out_valid}, 32'd0);
      check("midrst_idle", {31'd0, in_ready}, 32'd1);
    end
    full_op(16'h0001, 16'h0001, 1'b0, {16'h0002, 1'b0, 1'b0});

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
